serial_bit_source: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence detector. It accepts words over a valid/ready handshake and shifts them out one bit at a time on `x`, holding each bit for a fixed number of clock cycles. The detector samples `x` on every `clk` edge and has no enable input, so this block drives `x` low whenever it is not shifting.

---
 rtl/serial_bit_source.sv | 138 +++++++++++++
 tb/tb_serial_bit_source.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source: words accepted over valid/ready are shifted out on x, DIV clocks per bit.
// Optional macro SERIAL_PARITY_EN appends an even-parity bit to every frame.
module serial_bit_source #(
   parameter int WIDTH     = 8,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             frame_done
);

`ifdef SERIAL_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int IW = $clog2(FL);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(FL - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DW-1:0]    div_q, div_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             last_cycle;
   logic             accept;
   logic [(1<<IW)-1:0] frame_bits;
`ifdef SERIAL_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign last_cycle = (state_q == SHIFT) && (idx_q == IDX_LAST) && (div_q == DIV_LAST);
   assign din_ready  = !reset && ((state_q == IDLE) || last_cycle);
   assign accept     = din_valid && din_ready;

   // Frame bits in transmit order, padded to a power of two so idx selects without width games.
   generate
      for (genvar gi = 0; gi < (1 << IW); gi++) begin : g_bits
         if (gi < WIDTH) begin : g_data
            assign frame_bits[gi] = (MSB_FIRST != 0) ? word_d[WIDTH-1-gi] : word_d[gi];
         end
`ifdef SERIAL_PARITY_EN
         else if (gi == WIDTH) begin : g_par
            assign frame_bits[gi] = parity_d;
         end
`endif
         else begin : g_pad
            assign frame_bits[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      idx_d    = idx_q;
      div_d    = div_q;
`ifdef SERIAL_PARITY_EN
      parity_d = parity_q;
`endif
      if (accept) begin
         state_d  = SHIFT;
         word_d   = din;
         idx_d    = '0;
         div_d    = '0;
`ifdef SERIAL_PARITY_EN
         parity_d = ^din;
`endif
      end else if (state_q == SHIFT) begin
         if (last_cycle) begin
            state_d = IDLE;
            idx_d   = '0;
            div_d   = '0;
         end else if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // Outputs are precomputed from next state so x/x_valid come straight from flops.
   always_comb begin
      busy_d       = (state_d == SHIFT);
      x_valid_d    = busy_d;
      x_d          = busy_d && frame_bits[idx_d];
      frame_done_d = last_cycle;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         word_q       <= '0;
         idx_q        <= '0;
         div_q        <= '0;
         x_q          <= 1'b0;
         x_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         idx_q        <= idx_d;
         div_q        <= div_d;
         x_q          <= x_d;
         x_valid_q    <= x_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef SERIAL_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign x          = x_q;
   assign x_valid    = x_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: three instances cover MSB/LSB order and DIV=1/3.
module tb_serial_bit_source;

`ifdef SERIAL_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0] din_a, din_b, din_c;
   logic vin_a, vin_b, vin_c;
   logic rdy_a, rdy_b, rdy_c;
   logic x_a, x_b, x_c;
   logic xv_a, xv_b, xv_c;
   logic busy_a, busy_b, busy_c;
   logic fd_a, fd_b, fd_c;

   serial_bit_source #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_msb (
      .clk(clk), .reset(reset), .din(din_a), .din_valid(vin_a), .din_ready(rdy_a),
      .x(x_a), .x_valid(xv_a), .busy(busy_a), .frame_done(fd_a));
   serial_bit_source #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset(reset), .din(din_b), .din_valid(vin_b), .din_ready(rdy_b),
      .x(x_b), .x_valid(xv_b), .busy(busy_b), .frame_done(fd_b));
   serial_bit_source #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u_div3 (
      .clk(clk), .reset(reset), .din(din_c), .din_valid(vin_c), .din_ready(rdy_c),
      .x(x_c), .x_valid(xv_c), .busy(busy_c), .frame_done(fd_c));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   typedef struct {
      logic       vin;
      logic [7:0] din;
      logic       x;
      logic       xv;
      logic       rdy;
      logic       fd;
   } vec_t;

   vec_t vecs[12];
   int   n_vec;
   logic [17:0] s2;

`ifdef SERIAL_PARITY_EN
   task automatic send_a(input logic [7:0] d, input logic [8:0] exp_bits);
      vin_a = 1'b1;
      din_a = d;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         if (k == 0) vin_a = 1'b0;
         check($sformatf("par_%02h[%0d].x", d, k), x_a, exp_bits[8-k]);
         check($sformatf("par_%02h[%0d].xv", d, k), xv_a, 1'b1);
      end
      @(posedge clk); #1;
      check($sformatf("par_%02h.fd", d), fd_a, 1'b1);
      check($sformatf("par_%02h.xv_end", d), xv_a, 1'b0);
      $display("parity frame din=%02h done", d);
   endtask
`endif

   initial begin
      // Edge-by-edge expectations for 8'hA8, MSB first, DIV=1; extra din_valid pulses are ignored.
      vecs[0] = '{1'b1, 8'hA8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hA8, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_PARITY_EN
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      n_vec = 11;
      s2 = 18'b10101010_0_01010100_1;
`else
      vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      n_vec = 10;
      s2 = {16'b10101010_01010100, 2'b00};
`endif

      reset = 1'b1;
      vin_a = 1'b0; vin_b = 1'b0; vin_c = 1'b0;
      din_a = 8'h00; din_b = 8'h00; din_c = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst.x_a", x_a, 1'b0);
      check("rst.xv_a", xv_a, 1'b0);
      check("rst.busy_a", busy_a, 1'b0);
      check("rst.fd_a", fd_a, 1'b0);
      check("rst.rdy_a", rdy_a, 1'b0);
      check("rst.rdy_b", rdy_b, 1'b0);
      check("rst.x_c", x_c, 1'b0);
      reset = 1'b0;
      #1;
      check("rel.rdy_a", rdy_a, 1'b1);
      check("rel.rdy_c", rdy_c, 1'b1);

      for (int i = 0; i < n_vec; i++) begin
         vin_a = vecs[i].vin;
         din_a = vecs[i].din;
         @(posedge clk); #1;
         check($sformatf("t1[%0d].x", i), x_a, vecs[i].x);
         check($sformatf("t1[%0d].xv", i), xv_a, vecs[i].xv);
         check($sformatf("t1[%0d].rdy", i), rdy_a, vecs[i].rdy);
         check($sformatf("t1[%0d].fd", i), fd_a, vecs[i].fd);
      end
      vin_a = 1'b0;
      $display("single frame din=a8 msb-first done");

      // Back-to-back LSB-first frames with din_valid held high.
      vin_b = 1'b1;
      din_b = 8'h55;
      for (int k = 0; k < 2*FL; k++) begin
         @(posedge clk); #1;
         check($sformatf("t2[%0d].x", k), x_b, s2[17-k]);
         check($sformatf("t2[%0d].xv", k), xv_b, 1'b1);
         check($sformatf("t2[%0d].rdy", k), rdy_b, (k == FL-1) || (k == 2*FL-1));
         check($sformatf("t2[%0d].fd", k), fd_b, k == FL);
         if (k == FL-1) din_b = 8'h2A;
         if (k == 2*FL-1) vin_b = 1'b0;
      end
      @(posedge clk); #1;
      check("t2.end.x", x_b, 1'b0);
      check("t2.end.xv", xv_b, 1'b0);
      check("t2.end.fd", fd_b, 1'b1);
      $display("back-to-back frames din=55,2a lsb-first done");

      // DIV=3 bit hold on 8'hF0.
      vin_c = 1'b1;
      din_c = 8'hF0;
      for (int k = 0; k < 3*FL; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            vin_c = 1'b0;
            din_c = 8'h0F;
         end
         check($sformatf("t3[%0d].x", k), x_c, k < 12);
         check($sformatf("t3[%0d].xv", k), xv_c, 1'b1);
         check($sformatf("t3[%0d].fd", k), fd_c, 1'b0);
      end
      @(posedge clk); #1;
      check("t3.end.fd", fd_c, 1'b1);
      check("t3.end.xv", xv_c, 1'b0);
      check("t3.end.rdy", rdy_c, 1'b1);
      $display("div3 frame din=f0 done");

      // Reset while bit 4 of 8'hFF is on the line.
      vin_a = 1'b1;
      din_a = 8'hFF;
      @(posedge clk); #1;
      vin_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t4.pre.x", x_a, 1'b1);
      check("t4.pre.busy", busy_a, 1'b1);
      reset = 1'b1;
      #1;
      check("t4.rst.x", x_a, 1'b0);
      check("t4.rst.xv", xv_a, 1'b0);
      check("t4.rst.busy", busy_a, 1'b0);
      check("t4.rst.rdy", rdy_a, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("t4.rel.rdy", rdy_a, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         check($sformatf("t4[%0d].fd", k), fd_a, 1'b0);
         check($sformatf("t4[%0d].xv", k), xv_a, 1'b0);
      end
      $display("reset mid-frame din=ff done");

`ifdef SERIAL_PARITY_EN
      send_a(8'h07, 9'b0000_0111_1);
      send_a(8'h03, 9'b0000_0011_0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
